// File: rtl/matrix_frame_receiver.sv
// matrix_frame_receiver: deserialises row/col words off the 74HC164 link into 8x8 frames (clk, rst, en, srowdata, scoldata, sck -> row_word, col_word, word_valid, matdata, frame_valid, err)
module matrix_frame_receiver #(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            srowdata,
  input  logic            scoldata,
  input  logic            sck,
  output logic [7:0]      row_word,
  output logic [7:0]      col_word,
  output logic            word_valid,
  output logic [7:0][7:0] matdata,
  output logic            frame_valid,
  output logic            err
);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [2:0] sck_q;
  logic [1:0] row_q, col_q;
  logic [7:0] row_sh, col_sh, mask, mask_nx, row_nx, col_nx;
  logic [2:0] cnt;
  logic [IW-1:0] idle;
  logic [7:0][7:0] stage, stage_nx;
  logic rise, onehot;
  always_comb begin
    rise = en && sck_q[1] && !sck_q[2];
    row_nx = {row_sh[6:0], row_q[1]};
    col_nx = {col_sh[6:0], col_q[1]};
    onehot = (row_nx != 8'd0) && ((row_nx & (row_nx - 8'd1)) == 8'd0);
    mask_nx = mask | row_word;
    for (int i = 0; i < 8; i++) stage_nx[i] = row_word[i] ? col_word : stage[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q <= '0;
      row_q <= '0;
      col_q <= '0;
      row_sh <= '0;
      col_sh <= '0;
      cnt <= '0;
      idle <= '0;
      mask <= '0;
      stage <= '0;
      row_word <= '0;
      col_word <= '0;
      matdata <= '0;
      word_valid <= 1'b0;
      frame_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      row_q <= {row_q[0], srowdata};
      col_q <= {col_q[0], scoldata};
      word_valid <= 1'b0;
      frame_valid <= 1'b0;
      err <= 1'b0;
      if (!en) begin
        cnt <= '0;
        idle <= '0;
        mask <= '0;
      end else begin
        if (rise) begin
          row_sh <= row_nx;
          col_sh <= col_nx;
          cnt <= cnt + 3'd1;
          idle <= '0;
          if (cnt == 3'd7) begin
            if (onehot) begin
              row_word <= row_nx;
              col_word <= col_nx;
              word_valid <= 1'b1;
            end else err <= 1'b1;
          end
        end else if (cnt != 3'd0) begin
          if (idle == IW'(IDLE_TIMEOUT - 1)) begin
            cnt <= '0;
            idle <= '0;
          end else idle <= idle + IW'(1);
        end
        // staging lags the word registers by one cycle, so the frame emerges one cycle after word_valid
        if (word_valid) begin
          stage <= stage_nx;
          if (mask_nx == 8'hFF) begin
            matdata <= stage_nx;
            frame_valid <= 1'b1;
            mask <= '0;
          end else mask <= mask_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_frame_receiver.sv
// tb_matrix_frame_receiver: randomized self-checking bench against a frame-level reference model
module tb_matrix_frame_receiver;
  logic clk = 0, rst = 1, en = 0, srowdata = 0, scoldata = 0, sck = 0;
  logic [7:0] row_word, col_word;
  logic [7:0][7:0] matdata;
  logic word_valid, frame_valid, err;
  matrix_frame_receiver #(.IDLE_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .en(en), .srowdata(srowdata), .scoldata(scoldata), .sck(sck),
    .row_word(row_word), .col_word(col_word), .word_valid(word_valid),
    .matdata(matdata), .frame_valid(frame_valid), .err(err)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  int nwv = 0, nfv = 0, nerr = 0, cyc = 0, wv_cyc = 0, fv_cyc = 0;
  logic [7:0] m_mask = 0, m_row = 0, m_col = 0;
  logic [7:0] m_stage [8];
  logic [7:0][7:0] m_mat = '0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (word_valid) begin nwv++; wv_cyc = cyc; end
    if (frame_valid) begin nfv++; fv_cyc = cyc; end
    if (err) nerr++;
  end
  task automatic send_bits(int n, logic [7:0] r, logic [7:0] c);
    for (int b = 0; b < n; b++) begin
      srowdata = r[7-b];
      scoldata = c[7-b];
      repeat (4) @(negedge clk);
      sck = 1;
      repeat (4) @(negedge clk);
      sck = 0;
    end
  endtask
  task automatic send_word(logic [7:0] r, logic [7:0] c);
    int w0, f0, e0;
    logic fexp, ok;
    w0 = nwv; f0 = nfv; e0 = nerr; fexp = 0;
    ok = ($countones(r) == 1);
    send_bits(8, r, c);
    repeat (4) @(negedge clk);
    if (ok) begin
      m_row = r;
      m_col = c;
      for (int i = 0; i < 8; i++) if (r[i]) m_stage[i] = c;
      m_mask = m_mask | r;
      if (m_mask == 8'hFF) begin
        fexp = 1;
        for (int i = 0; i < 8; i++) m_mat[i] = m_stage[i];
        m_mask = 0;
      end
    end
    chk("word_valid_count", 64'(nwv - w0), 64'(ok));
    chk("err_count", 64'(nerr - e0), 64'(!ok));
    chk("frame_valid_count", 64'(nfv - f0), 64'(fexp));
    chk("row_word", 64'(row_word), 64'(m_row));
    chk("col_word", 64'(col_word), 64'(m_col));
    chk("matdata", matdata, m_mat);
    if (fexp) chk("frame_latency", 64'(fv_cyc - wv_cyc), 64'd1);
  endtask
  task automatic check_idle_outputs(string tag);
    chk({tag, "_row_word"}, 64'(row_word), 64'(m_row));
    chk({tag, "_col_word"}, 64'(col_word), 64'(m_col));
    chk({tag, "_matdata"}, matdata, m_mat);
    chk({tag, "_pulses"}, 64'({word_valid, frame_valid, err}), 64'd0);
  endtask
  initial begin
    for (int i = 0; i < 8; i++) m_stage[i] = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 0;
    en = 1;
    repeat (3) @(negedge clk);
    send_word(8'h04, 8'hA5);
    for (int i = 0; i < 8; i++) send_word(8'(1 << i), 8'(17 * (i + 1)));
    for (int i = 7; i >= 0; i--) send_word(8'(1 << i), 8'(17 * (i + 1)));
    for (int i = 0; i < 4; i++) send_word(8'(1 << i), 8'($urandom));
    send_word(8'h06, 8'h99);
    for (int i = 4; i < 8; i++) send_word(8'(1 << i), 8'($urandom));
    send_word(8'h04, 8'hFF);
    send_word(8'h04, 8'h0F);
    for (int i = 0; i < 8; i++) if (i != 2) send_word(8'(1 << i), 8'($urandom));
    chk("dup_row2", 64'(matdata[2]), 64'h0F);
    send_bits(5, 8'hAA, 8'h55);
    repeat (70) @(negedge clk);
    send_word(8'h01, 8'h3C);
    begin
      int w0, e0, f0;
      w0 = nwv; e0 = nerr; f0 = nfv;
      en = 0;
      m_mask = 0;
      send_bits(8, 8'h08, 8'h77);
      repeat (4) @(negedge clk);
      chk("en_low_pulses", 64'((nwv - w0) + (nerr - e0) + (nfv - f0)), 64'd0);
      check_idle_outputs("en_low");
      en = 1;
      repeat (2) @(negedge clk);
    end
    for (int k = 0; k < 40; k++)
      send_word(($urandom % 6 == 0) ? 8'($urandom) : 8'(1 << ($urandom % 8)), 8'($urandom));
    for (int i = 0; i < 4; i++) send_word(8'(1 << i), 8'($urandom));
    send_bits(3, 8'h10, 8'hF0);
    rst = 1;
    sck = 0;
    m_mask = 0; m_row = 0; m_col = 0; m_mat = '0;
    for (int i = 0; i < 8; i++) m_stage[i] = 0;
    repeat (2) @(negedge clk);
    check_idle_outputs("mid_reset");
    rst = 0;
    repeat (2) @(negedge clk);
    for (int i = 7; i >= 0; i--) send_word(8'(1 << ((i * 3) % 8)), 8'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
